// File: rtl/gemmm2s_pkg.sv
// Shared definitions for the GEM MM2S AW path: completion-scheduler state
// encoding and bus geometry shared with last_beat_calc.
package gemmm2s_pkg;

  localparam int unsigned AXI_DATA_WIDTH   = 64;
  localparam int unsigned BEAT_BYTES       = AXI_DATA_WIDTH / 8;
  localparam int unsigned AXI_ADDR_WIDTH   = 12;
  localparam int unsigned DMACPL_PEND_W    = 4;
  localparam int unsigned DMACPL_MAX_RUN   = 16;

  typedef enum logic {
    PASS = 1'b0,
    HOLD = 1'b1
  } dmacpl_sched_state_t;

endpackage

// File: rtl/dma_complete_scheduler_sat_updown_counter.sv
// Saturating up/down counter with a sticky overflow flag; an increment that
// would exceed all-ones is dropped and flagged.
module sat_updown_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_overflow
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (i_inc && !i_dec) begin
      if (count_q == '1) overflow_d = 1'b1;
      else               count_d    = count_q + WIDTH'(1);
    end else if (i_dec && !i_inc && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_count    = count_q;
  assign o_overflow = overflow_q;

endmodule

// File: rtl/dma_complete_scheduler.sv
// Slots DMA-complete pulses into non-handshake cycles of the AW path.
// DMACPL_STARVE_GUARD_EN builds the forced HOLD slot after MAX_BEAT_RUN beats.
module dma_complete_scheduler
  import gemmm2s_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = AXI_ADDR_WIDTH,
  parameter int unsigned PENDING_WIDTH = DMACPL_PEND_W,
  parameter int unsigned MAX_BEAT_RUN  = DMACPL_MAX_RUN
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_doorbell,
  input  logic [ADDR_WIDTH-1:0]    s_addr_data,
  input  logic                     s_addr_valid,
  output logic                     s_addr_ready,
  output logic [ADDR_WIDTH-1:0]    m_addr_data,
  output logic                     m_addr_valid,
  input  logic                     m_addr_ready,
  output logic                     o_dma_complete,
  output logic [PENDING_WIDTH-1:0] o_pending,
  output logic                     o_overflow
);

  if (MAX_BEAT_RUN < 1) begin : g_bad_run
    $error("MAX_BEAT_RUN must be at least 1");
  end

  logic hold;
  logic beat;
  logic pending_nz;

  assign m_addr_data    = s_addr_data;
  assign m_addr_valid   = s_addr_valid && !hold;
  assign s_addr_ready   = m_addr_ready && !hold;
  assign beat           = m_addr_valid && m_addr_ready;
  assign pending_nz     = (o_pending != '0);
  assign o_dma_complete = pending_nz && !beat;

  sat_updown_counter #(
    .WIDTH (PENDING_WIDTH)
  ) u_pending (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_inc      (i_doorbell),
    .i_dec      (o_dma_complete),
    .o_count    (o_pending),
    .o_overflow (o_overflow)
  );

`ifdef DMACPL_STARVE_GUARD_EN
  localparam int unsigned RUN_W = $clog2(MAX_BEAT_RUN + 1);

  dmacpl_sched_state_t state_q, state_d;
  logic [RUN_W-1:0]    run_q, run_d;

  // HOLD only follows a completed handshake, so no offered beat is retracted.
  always_comb begin
    state_d = state_q;
    run_d   = '0;
    case (state_q)
      PASS: begin
        if (beat && pending_nz) begin
          if (run_q == RUN_W'(MAX_BEAT_RUN - 1)) state_d = HOLD;
          else                                   run_d   = run_q + RUN_W'(1);
        end
      end
      HOLD:    state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PASS;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  assign hold = (state_q == HOLD);
`else
  assign hold = 1'b0;
`endif

endmodule
